// File: rtl/rackctl_txn_ctrl_if.sv
// SURF register-bus bundle between the rackctl transaction controller and
// the register file. The controller is the master: it issues one-cycle
// read/write strobes and waits for a one-cycle ack carrying read data.
interface rackctl_txn_ctrl_if;
  logic [22:0] addr;
  logic [31:0] wdat;
  logic        wr;
  logic        rd;
  logic        ack;
  logic [31:0] rdat;

  modport master (
    output addr,
    output wdat,
    output wr,
    output rd,
    input  ack,
    input  rdat
  );

  modport slave (
    input  addr,
    input  wdat,
    input  wr,
    input  rd,
    output ack,
    output rdat
  );
endinterface

// File: rtl/rackctl_txn_ctrl.sv
// rackctl transaction controller, SURF side.
// Mode 0 turns each received link transaction into one register-bus access
// and returns the response word. Mode 1 arbitrates two local message sources
// round-robin and spaces consecutive done pulses by HOLDOFF+1 cycles.
// Mode 1 is left only through reset.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_RESET     | one cycle after reset, outputs still at reset values
// ST_M0_IDLE   | mode 0, waiting for a link transaction or mode-1 request
// ST_BUS_ISSUE | drive the read or write strobe for the captured access
// ST_BUS_WAIT  | wait for bus ack or the access timeout
// ST_DONE      | done pulse is on the outputs; may enter mode 1 from here
// ST_M1_HOLD   | mode 1 hold-off between messages
// ST_M1_IDLE   | mode 1, grant the next requesting source
module rackctl_txn_ctrl #(
  parameter int unsigned TIMEOUT  = 100,
  parameter int unsigned HOLDOFF  = 40,
  parameter logic [31:0] ERR_RESP = 32'hDEADDEAD
) (
  input  logic                 rxclk_i,
  input  logic                 rst_i,
  input  logic                 mode1_en_i,
  output logic                 mode_o,
  input  logic [23:0]          txn_addr_i,
  input  logic [31:0]          txn_data_i,
  input  logic                 txn_valid_flag_i,
  output logic                 txn_done_flag_o,
  output logic [31:0]          txn_resp_o,
  output logic                 mode1_txn_type_o,
  rackctl_txn_ctrl_if.master   bus,
  output logic                 timeout_o,
  input  logic [1:0]           req_i,
  input  logic [1:0]           req_type_i,
  input  logic [63:0]          req_dat_i,
  output logic [1:0]           grant_o
);

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_M0_IDLE   = 3'd1;
  localparam logic [2:0] ST_BUS_ISSUE = 3'd2;
  localparam logic [2:0] ST_BUS_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_M1_HOLD   = 3'd5;
  localparam logic [2:0] ST_M1_IDLE   = 3'd6;

  // Timeout fires when the counter, cleared on BUS_WAIT entry, equals TIMEOUT.
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  // Hold-off starts at 0 and lasts HOLDOFF cycles, so the last count is HOLDOFF-1.
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  logic [2:0]  state;
  logic [23:0] addr_q;
  logic [31:0] data_q;
  logic [7:0]  tmo_cnt;
  logic [7:0]  hold_cnt;
  logic        prio;
  logic        sel;

  logic        mode_q;
  logic        done_q;
  logic [31:0] resp_q;
  logic        type_q;
  logic [22:0] bus_addr_q;
  logic [31:0] bus_wdat_q;
  logic        bus_wr_q;
  logic        bus_rd_q;
  logic        timeout_q;
  logic [1:0]  grant_q;

  // Round-robin pick: with both sources asking, the favoured one wins.
  always_comb begin
    sel = 1'b0;
    if (req_i[0] && req_i[1]) begin
      sel = prio;
    end else begin
      sel = req_i[1];
    end
  end

  // Main controller state machine; every output is a register written here.
  always_ff @(posedge rxclk_i) begin
    if (rst_i) begin
      state      <= ST_RESET;
      addr_q     <= '0;
      data_q     <= '0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
      prio       <= 1'b0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_q     <= '0;
      type_q     <= 1'b0;
      bus_addr_q <= '0;
      bus_wdat_q <= '0;
      bus_wr_q   <= 1'b0;
      bus_rd_q   <= 1'b0;
      timeout_q  <= 1'b0;
      grant_q    <= '0;
    end else begin
      bus_wr_q <= 1'b0;
      bus_rd_q <= 1'b0;
      done_q   <= 1'b0;
      grant_q  <= '0;

      case (state)
        ST_RESET: begin
          state <= ST_M0_IDLE;
        end

        ST_M0_IDLE: begin
          if (txn_valid_flag_i) begin
            addr_q <= txn_addr_i;
            data_q <= txn_data_i;
            state  <= ST_BUS_ISSUE;
          end else if (mode1_en_i) begin
            mode_q   <= 1'b1;
            hold_cnt <= '0;
            state    <= ST_M1_HOLD;
          end
        end

        ST_BUS_ISSUE: begin
          bus_addr_q <= addr_q[22:0];
          bus_wdat_q <= data_q;
          if (addr_q[23]) begin
            bus_rd_q <= 1'b1;
          end else begin
            bus_wr_q <= 1'b1;
          end
          tmo_cnt <= '0;
          state   <= ST_BUS_WAIT;
        end

        ST_BUS_WAIT: begin
          // An ack wins over a timeout landing in the same cycle.
          if (bus.ack) begin
            resp_q <= addr_q[23] ? bus.rdat : data_q;
            type_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else if (tmo_cnt == TMO_LIMIT) begin
            resp_q    <= ERR_RESP;
            type_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end else if (tmo_cnt != 8'hFF) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          // A deferred mode-1 request is taken here so mode_o rises right after done.
          if (mode1_en_i) begin
            mode_q   <= 1'b1;
            hold_cnt <= '0;
            state    <= ST_M1_HOLD;
          end else begin
            state <= ST_M0_IDLE;
          end
        end

        ST_M1_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_M1_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        ST_M1_IDLE: begin
          if (|req_i) begin
            grant_q  <= sel ? 2'b10 : 2'b01;
            resp_q   <= sel ? req_dat_i[63:32] : req_dat_i[31:0];
            type_q   <= req_type_i[sel];
            done_q   <= 1'b1;
            prio     <= ~sel;
            hold_cnt <= '0;
            state    <= ST_M1_HOLD;
          end
        end

        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

  assign mode_o           = mode_q;
  assign txn_done_flag_o  = done_q;
  assign txn_resp_o       = resp_q;
  assign mode1_txn_type_o = type_q;
  assign bus.addr         = bus_addr_q;
  assign bus.wdat         = bus_wdat_q;
  assign bus.wr           = bus_wr_q;
  assign bus.rd           = bus_rd_q;
  assign timeout_o        = timeout_q;
  assign grant_o          = grant_q;

endmodule

// File: tb/tb_rackctl_txn_ctrl.sv
// Directed bench for rackctl_txn_ctrl with default parameters.
module tb_rackctl_txn_ctrl;
  localparam int TIMEOUT = 100;
  localparam int HOLDOFF = 40;

  logic        rxclk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mode1_en_i = 1'b0;
  logic        mode_o;
  logic [23:0] txn_addr_i = '0;
  logic [31:0] txn_data_i = '0;
  logic        txn_valid_flag_i = 1'b0;
  logic        txn_done_flag_o;
  logic [31:0] txn_resp_o;
  logic        mode1_txn_type_o;
  logic        timeout_o;
  logic [1:0]  req_i = '0;
  logic [1:0]  req_type_i = '0;
  logic [63:0] req_dat_i = '0;
  logic [1:0]  grant_o;

  rackctl_txn_ctrl_if bus_if ();

  rackctl_txn_ctrl dut (
    .rxclk_i          (rxclk_i),
    .rst_i            (rst_i),
    .mode1_en_i       (mode1_en_i),
    .mode_o           (mode_o),
    .txn_addr_i       (txn_addr_i),
    .txn_data_i       (txn_data_i),
    .txn_valid_flag_i (txn_valid_flag_i),
    .txn_done_flag_o  (txn_done_flag_o),
    .txn_resp_o       (txn_resp_o),
    .mode1_txn_type_o (mode1_txn_type_o),
    .bus              (bus_if),
    .timeout_o        (timeout_o),
    .req_i            (req_i),
    .req_type_i       (req_type_i),
    .req_dat_i        (req_dat_i),
    .grant_o          (grant_o)
  );

  always #5 rxclk_i = ~rxclk_i;

  int cyc = 0;
  int n_done = 0;
  int n_strb = 0;
  int n_chk = 0;
  int n_pass = 0;

  // Cycle index and event counts, sampled on the falling edge.
  always @(negedge rxclk_i) begin
    cyc = cyc + 1;
    if (txn_done_flag_o) n_done = n_done + 1;
    if (bus_if.wr || bus_if.rd) n_strb = n_strb + 1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; the current cycle is then cyc+1.
  task automatic tick();
    @(posedge rxclk_i);
    #1;
  endtask

  task automatic wait_strobe(input string tag, input int limit, output int c);
    int k;
    k = 0;
    tick();
    while (!(bus_if.wr || bus_if.rd) && k < limit) begin
      tick();
      k++;
    end
    c = cyc + 1;
    chk_eq({tag, "_strobe_seen"}, 64'(bus_if.wr || bus_if.rd), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int limit, output int c);
    int k;
    k = 0;
    tick();
    while (!txn_done_flag_o && k < limit) begin
      tick();
      k++;
    end
    c = cyc + 1;
    chk_eq({tag, "_done_seen"}, 64'(txn_done_flag_o), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_mode"},  64'(mode_o), 64'd0);
    chk_eq({tag, "_done"},  64'(txn_done_flag_o), 64'd0);
    chk_eq({tag, "_resp"},  64'(txn_resp_o), 64'd0);
    chk_eq({tag, "_type"},  64'(mode1_txn_type_o), 64'd0);
    chk_eq({tag, "_baddr"}, 64'(bus_if.addr), 64'd0);
    chk_eq({tag, "_bwdat"}, 64'(bus_if.wdat), 64'd0);
    chk_eq({tag, "_bstrb"}, 64'({bus_if.wr, bus_if.rd}), 64'd0);
    chk_eq({tag, "_grant"}, 64'(grant_o), 64'd0);
    chk_eq({tag, "_tmo"},   64'(timeout_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s, d, m, g0, g1, g2, base;
    bus_if.ack  = 1'b0;
    bus_if.rdat = '0;

    // Reset state
    repeat (3) tick();
    chk_all_zero("rst_hold");
    rst_i = 1'b0;
    chk_all_zero("rst_fall");
    tick();
    tick();

    // Mode-0 write, ack 5 cycles after the strobe
    txn_addr_i = 24'h012345;
    txn_data_i = 32'hCAFEF00D;
    txn_valid_flag_i = 1'b1;
    t = cyc + 1;
    base = n_strb;
    tick();
    txn_valid_flag_i = 1'b0;
    wait_strobe("wr", 10, s);
    chk_eq("wr_strobe_lat", 64'(s - t), 64'd2);
    chk_eq("wr_strobe_kind", 64'({bus_if.wr, bus_if.rd}), 64'b10);
    chk_eq("wr_addr", 64'(bus_if.addr), 64'h012345);
    chk_eq("wr_wdat", 64'(bus_if.wdat), 64'hCAFEF00D);
    repeat (5) tick();
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    chk_eq("wr_done", 64'(txn_done_flag_o), 64'd1);
    chk_eq("wr_resp", 64'(txn_resp_o), 64'hCAFEF00D);
    chk_eq("wr_type", 64'(mode1_txn_type_o), 64'd0);
    tick();
    chk_eq("wr_done_pulse", 64'(txn_done_flag_o), 64'd0);
    chk_eq("wr_resp_held", 64'(txn_resp_o), 64'hCAFEF00D);
    chk_eq("wr_one_strobe", 64'(n_strb - base), 64'd1);

    // Mode-0 read, ack 2 cycles after the strobe
    txn_addr_i = 24'h800010;
    txn_data_i = 32'h0;
    txn_valid_flag_i = 1'b1;
    tick();
    txn_valid_flag_i = 1'b0;
    wait_strobe("rd", 10, s);
    chk_eq("rd_strobe_kind", 64'({bus_if.wr, bus_if.rd}), 64'b01);
    chk_eq("rd_addr", 64'(bus_if.addr), 64'h000010);
    repeat (2) tick();
    bus_if.ack  = 1'b1;
    bus_if.rdat = 32'h11223344;
    tick();
    bus_if.ack  = 1'b0;
    bus_if.rdat = 32'h0;
    chk_eq("rd_done", 64'(txn_done_flag_o), 64'd1);
    chk_eq("rd_resp", 64'(txn_resp_o), 64'h11223344);
    chk_eq("rd_type", 64'(mode1_txn_type_o), 64'd0);
    chk_eq("rd_no_tmo", 64'(timeout_o), 64'd0);

    // Timeout: read with no ack, then a late ack
    tick();
    txn_addr_i = 24'h800020;
    txn_valid_flag_i = 1'b1;
    t = cyc + 1;
    tick();
    txn_valid_flag_i = 1'b0;
    wait_done("tmo", TIMEOUT + 20, d);
    chk_eq("tmo_latency", 64'(d - t), 64'(TIMEOUT + 3));
    chk_eq("tmo_resp", 64'(txn_resp_o), 64'hDEADDEAD);
    chk_eq("tmo_flag", 64'(timeout_o), 64'd1);
    repeat (9) tick();
    base = n_done;
    bus_if.ack  = 1'b1;
    bus_if.rdat = 32'h99999999;
    tick();
    bus_if.ack  = 1'b0;
    repeat (5) tick();
    chk_eq("tmo_late_ack", 64'(n_done - base), 64'd0);
    chk_eq("tmo_resp_held", 64'(txn_resp_o), 64'hDEADDEAD);
    chk_eq("tmo_sticky", 64'(timeout_o), 64'd1);

    // Reset in the middle of an access
    txn_addr_i = 24'h000100;
    txn_data_i = 32'h00000055;
    txn_valid_flag_i = 1'b1;
    tick();
    txn_valid_flag_i = 1'b0;
    wait_strobe("rmid", 10, s);
    repeat (2) tick();
    base = n_done;
    rst_i = 1'b1;
    repeat (2) tick();
    chk_all_zero("rmid");
    bus_if.ack = 1'b1;
    rst_i = 1'b0;
    tick();
    tick();
    bus_if.ack = 1'b0;
    repeat (3) tick();
    chk_eq("rmid_no_done", 64'(n_done - base), 64'd0);
    txn_addr_i = 24'h000200;
    txn_data_i = 32'h12345678;
    txn_valid_flag_i = 1'b1;
    tick();
    txn_valid_flag_i = 1'b0;
    wait_strobe("rnext", 10, s);
    chk_eq("rnext_addr", 64'(bus_if.addr), 64'h000200);
    tick();
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    chk_eq("rnext_done", 64'(txn_done_flag_o), 64'd1);
    chk_eq("rnext_resp", 64'(txn_resp_o), 64'h12345678);
    tick();

    // Mode entry deferred behind a same-cycle transaction
    req_i      = 2'b11;
    req_type_i = 2'b10;
    req_dat_i  = {32'hBBBBBBBB, 32'hAAAAAAAA};
    mode1_en_i = 1'b1;
    txn_addr_i = 24'h800030;
    txn_valid_flag_i = 1'b1;
    tick();
    txn_valid_flag_i = 1'b0;
    wait_strobe("ment", 10, s);
    chk_eq("ment_rd", 64'(bus_if.rd), 64'd1);
    chk_eq("ment_mode_low", 64'(mode_o), 64'd0);
    bus_if.ack  = 1'b1;
    bus_if.rdat = 32'h0BADF00D;
    tick();
    bus_if.ack  = 1'b0;
    d = cyc + 1;
    chk_eq("ment_done", 64'(txn_done_flag_o), 64'd1);
    chk_eq("ment_resp", 64'(txn_resp_o), 64'h0BADF00D);
    chk_eq("ment_mode_at_done", 64'(mode_o), 64'd0);
    tick();
    m = cyc + 1;
    chk_eq("ment_mode_rise", 64'(mode_o), 64'd1);
    chk_eq("ment_rise_cycle", 64'(m - d), 64'd1);
    mode1_en_i = 1'b0;
    base = n_strb;
    txn_addr_i = 24'h000040;
    txn_valid_flag_i = 1'b1;
    tick();
    txn_valid_flag_i = 1'b0;

    // Mode-1 fairness with both sources requesting
    wait_done("g0", HOLDOFF + 20, g0);
    chk_eq("g0_latency", 64'(g0 - m), 64'(HOLDOFF + 1));
    chk_eq("g0_grant", 64'(grant_o), 64'b01);
    chk_eq("g0_resp", 64'(txn_resp_o), 64'hAAAAAAAA);
    chk_eq("g0_type", 64'(mode1_txn_type_o), 64'd0);
    repeat (10) tick();
    chk_eq("g0_resp_held", 64'(txn_resp_o), 64'hAAAAAAAA);
    chk_eq("g0_grant_pulse", 64'(grant_o), 64'b00);
    wait_done("g1", HOLDOFF + 20, g1);
    chk_eq("g1_spacing", 64'(g1 - g0), 64'(HOLDOFF + 1));
    chk_eq("g1_grant", 64'(grant_o), 64'b10);
    chk_eq("g1_resp", 64'(txn_resp_o), 64'hBBBBBBBB);
    chk_eq("g1_type", 64'(mode1_txn_type_o), 64'd1);
    wait_done("g2", HOLDOFF + 20, g2);
    chk_eq("g2_spacing", 64'(g2 - g1), 64'(HOLDOFF + 1));
    chk_eq("g2_grant", 64'(grant_o), 64'b01);
    chk_eq("g2_resp", 64'(txn_resp_o), 64'hAAAAAAAA);
    chk_eq("g2_type", 64'(mode1_txn_type_o), 64'd0);
    chk_eq("m1_mode_stays", 64'(mode_o), 64'd1);
    chk_eq("m1_valid_ignored", 64'(n_strb - base), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
